uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Downstream consumer of the UART receiver.
- Takes received bytes (data / data_rec), acknowledges each one via clr, and assembles fixed-length framed commands for the DDS control registers.
- Frame format: header, address, payload_bytes of big-endian data, 8-bit additive checksum.
- Emits a one-cycle command strobe with held address/data; flags checksum errors and inter-byte timeouts.

Parameters:
header_byte, 8'h55, frame start marker.
payload_bytes, 4, number of data bytes per frame (1..8).
timeout_cycles, 1_000_000, maximum clk cycles between accepted bytes inside a frame (10 ms at 100 MHz).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset (0 = reset).
rx_data  input  8  byte from the UART receiver's data output.
rx_rec  input  1  byte-available flag from the UART receiver's data_rec.
rx_clr  output  1  one-cycle acknowledge to the receiver's clr input.
cmd_addr  output  8  address of last good frame.
cmd_data  output  8*payload_bytes  payload of last good frame; first received byte is the MSB.
cmd_valid  output  1  one-cycle strobe for a good frame.
cmd_err  output  1  one-cycle strobe for a bad or aborted frame.
err_type  output  1  cause of last cmd_err: 0 = checksum, 1 = timeout; held.

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, checksum accumulator 0, byte counter 0, timeout counter 0.
- Byte acceptance: accept on a cycle where rx_rec=1, rx_clr=0 and rx_clr was 0 on the previous cycle.
  - This two-cycle guard covers the receiver's registered data_rec clear.
  - rx_clr is registered and asserted for exactly 1 cycle, on the cycle after acceptance.
  - Every byte is acknowledged, including discarded ones.
- States (registered):
  - IDLE: accepted byte == header_byte -> ADDR, sum cleared, timeout counter cleared. Any other byte is discarded; stay IDLE.
  - ADDR: accepted byte stored as the address and loaded into sum; byte counter = 0 -> PAYLOAD.
  - PAYLOAD: accepted byte shifted into the data shift register at the LSB (earlier bytes move up); sum += byte, mod 256. After the payload_bytes-th byte -> CHECK.
  - CHECK: on the accepted byte:
    - byte == sum: cmd_addr/cmd_data load on the next edge, cmd_valid=1 that cycle.
    - otherwise: cmd_err=1, err_type=0, cmd_addr/cmd_data unchanged.
    - Either way -> IDLE.
- Latency: cmd_valid/cmd_err rise 1 cycle after the checksum byte is accepted (same cycle as its rx_clr).
- Header value inside ADDR/PAYLOAD/CHECK is ordinary data; there is no resync.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle and clears on each accepted byte.
  - Reaching timeout_cycles-1: -> IDLE, cmd_err=1, err_type=1, partial frame dropped, outputs unchanged.
  - If a byte is accepted on the same cycle the limit is reached, the byte wins and no timeout occurs.
  - Counter width: clog2(timeout_cycles)+1; it saturates and never wraps.
- cmd_valid and cmd_err are never both 1.
- Reset asserted mid-frame: the partial frame is dropped, and rx_clr drops immediately.
- The receiver's set-over-clr priority applies: if a new byte lands on the cycle rx_clr is high, rx_rec stays 1 and that byte is accepted after the guard cycle.

Test Plan:
1. Good frame: bytes 55 01 12 34 56 78 15, spaced 10 cycles apart.
   -> one cmd_valid pulse, cmd_addr=01, cmd_data=32'h12345678, no cmd_err.
   -> exactly 7 rx_clr pulses, each 1 cycle after its rx_rec rise.
2. Bad checksum: 55 01 12 34 56 78 16.
   -> cmd_err=1 for 1 cycle, err_type=0.
   -> cmd_addr/cmd_data keep the previous values (01 / 12345678 after test 1).
3. Garbage then frame: A5 00 55 02 00 00 00 FF 01.
   -> A5 and 00 are acknowledged and ignored.
   -> cmd_valid with cmd_addr=02, cmd_data=000000FF.
4. Timeout with timeout_cycles=100: send 55 03 11, then idle 100 cycles.
   -> cmd_err pulse with err_type=1, state IDLE.
   -> A following good frame 55 03 00 00 00 01 04 yields cmd_valid, cmd_data=00000001.
5. Header as payload: 55 04 55 55 55 55 58.
   -> cmd_valid, cmd_addr=04, cmd_data=55555555.
6. Reset mid-frame: pull rst low after 55 01 12.
   -> all outputs 0 immediately.
   -> After release, 55 01 12 34 56 78 15 decodes correctly; no stale bytes.
   -> rx_rec held high continuously produces no duplicate acceptance.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Framed command parser behind the UART receiver: header, address, big-endian payload, checksum.
// Acknowledges every received byte and strobes good/bad frames towards the DDS control registers.
module uart_cmd_parser #(
  parameter logic [7:0]  header_byte    = 8'h55,
  parameter int unsigned payload_bytes  = 4,
  parameter int unsigned timeout_cycles = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_rec,
  output logic                       rx_clr,
  output logic [7:0]                 cmd_addr,
  output logic [8*payload_bytes-1:0] cmd_data,
  output logic                       cmd_valid,
  output logic                       cmd_err,
  output logic                       err_type
);

  localparam int unsigned DataW = 8 * payload_bytes;
  localparam int unsigned CntW  = $clog2(payload_bytes) + 1;
  localparam int unsigned TmoW  = $clog2(timeout_cycles) + 1;
  localparam logic [CntW-1:0] LastCnt  = CntW'(payload_bytes - 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(timeout_cycles - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StPayload, StCheck} state_e;

  state_e            state_q, state_d;
  logic              rx_clr_q, rx_clr_d;
  logic              clr_prev_q;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        addr_q, addr_d;
  logic [DataW-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [7:0]        cmd_addr_q, cmd_addr_d;
  logic [DataW-1:0]  cmd_data_q, cmd_data_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_err_q, cmd_err_d;
  logic              err_type_q, err_type_d;
  logic              accept;

  // The receiver clears data_rec one cycle after our clr, so skip the two cycles around a clr.
  assign accept = rx_rec & ~rx_clr_q & ~clr_prev_q;

  always_comb begin
    state_d     = state_q;
    rx_clr_d    = accept;
    sum_d       = sum_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    err_type_d  = err_type_q;

    if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (accept) begin
      tmo_d = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + TmoW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept && rx_data == header_byte) begin
          state_d = StAddr;
          sum_d   = '0;
        end
      end
      StAddr: begin
        if (accept) begin
          addr_d  = rx_data;
          sum_d   = rx_data;
          cnt_d   = '0;
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (accept) begin
          shift_d      = shift_q << 8;
          shift_d[7:0] = rx_data;
          sum_d        = sum_q + rx_data;
          cnt_d        = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (accept) begin
          if (rx_data == sum_q) begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = addr_q;
            cmd_data_d  = shift_q;
          end else begin
            cmd_err_d  = 1'b1;
            err_type_d = 1'b0;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A byte arriving on the limit cycle takes precedence over the timeout.
    if (state_q != StIdle && !accept && tmo_q >= TmoLimit) begin
      state_d    = StIdle;
      cmd_err_d  = 1'b1;
      err_type_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rx_clr_q    <= 1'b0;
      clr_prev_q  <= 1'b0;
      sum_q       <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      err_type_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_clr_q    <= rx_clr_d;
      clr_prev_q  <= rx_clr_q;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      err_type_q  <= err_type_d;
    end
  end

  assign rx_clr    = rx_clr_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;
  assign err_type  = err_type_q;

endmodule
